// File: rtl/reg_desloc_saida_pkg.sv
// Shared definitions for the serial unload register and its matching receiver:
// state encoding, default word width and the even-parity helper.
package reg_desloc_saida_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int PARITY_MAX_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  // Zero-extension does not change the XOR, so one helper serves any width up to 64.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/reg_desloc_cnt.sv
// Bit counter for the serial unload register: clear/enable, saturates at WIDTH,
// flags the cycle in which the final data bit is on the line.
module reg_desloc_cnt #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_last
);

  logic [CW-1:0] r_count;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != CW'(WIDTH))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/reg_desloc_saida.sv
// Parallel-in / serial-out unload register, MSB first, falling-edge clocked.
// Optional trailing even-parity bit when REG_DESLOC_PARITY_EN is defined.
module reg_desloc_saida
  import reg_desloc_saida_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic             r_sout, w_sout_next;
  logic             r_valid, w_valid_next;
  logic             r_done, w_done_next;
  logic             r_ready, w_ready_next;
  logic             w_cnt_clr, w_cnt_en;
  logic [CW-1:0]    w_count;
  logic             w_last;
  logic             w_pre_last;
`ifdef REG_DESLOC_PARITY_EN
  logic             r_par, w_par_next;
`endif

  reg_desloc_cnt #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_count),
    .o_last  (w_last)
  );

  // Registered done must rise on the edge that puts the final bit on sout.
  assign w_pre_last = (w_count == CW'(WIDTH - 2));

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (ld) w_state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_last) begin
`ifdef REG_DESLOC_PARITY_EN
          w_state_next = ST_PAR;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
      ST_PAR:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shift_next = r_shift;
    w_sout_next  = r_sout;
    w_valid_next = r_valid;
    w_done_next  = r_done;
    w_ready_next = r_ready;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
`ifdef REG_DESLOC_PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        if (ld) begin
          w_shift_next = d;
          w_sout_next  = d[WIDTH-1];
          w_valid_next = 1'b1;
          w_done_next  = 1'b0;
          w_ready_next = 1'b0;
          w_cnt_clr    = 1'b1;
`ifdef REG_DESLOC_PARITY_EN
          w_par_next   = calc_parity(PARITY_MAX_W'(d));
`endif
        end
      end
      ST_SHIFT: begin
        w_cnt_en = 1'b1;
        if (w_last) begin
`ifdef REG_DESLOC_PARITY_EN
          w_sout_next  = r_par;
          w_valid_next = 1'b1;
          w_done_next  = 1'b1;
          w_ready_next = 1'b0;
`else
          w_sout_next  = 1'b0;
          w_valid_next = 1'b0;
          w_done_next  = 1'b0;
          w_ready_next = 1'b1;
`endif
        end else begin
          w_shift_next = r_shift << 1;
          w_sout_next  = r_shift[WIDTH-2];
          w_valid_next = 1'b1;
`ifdef REG_DESLOC_PARITY_EN
          w_done_next  = 1'b0;
`else
          w_done_next  = w_pre_last;
`endif
        end
      end
      default: begin
        w_sout_next  = 1'b0;
        w_valid_next = 1'b0;
        w_done_next  = 1'b0;
        w_ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
`ifdef REG_DESLOC_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_shift <= w_shift_next;
      r_sout  <= w_sout_next;
      r_valid <= w_valid_next;
      r_done  <= w_done_next;
      r_ready <= w_ready_next;
`ifdef REG_DESLOC_PARITY_EN
      r_par   <= w_par_next;
`endif
    end
  end

  assign ready      = r_ready;
  assign sout       = r_sout;
  assign sout_valid = r_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_reg_desloc_saida.sv
// Self-checking bench for reg_desloc_saida: directed scenarios plus random traffic,
// compared each cycle against a per-word expected-cycle queue.
module tb_reg_desloc_saida;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d;
  logic         ld;
  logic         ready, sout, sout_valid, done;

  int checks_cnt;
  int errors_cnt;

  typedef struct packed {
    logic ready;
    logic valid;
    logic done;
    logic sout;
  } obs_t;

  obs_t exp_q[$];
  obs_t cur_exp;
  obs_t idle_obs;

  reg_desloc_saida #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (d),
    .ld         (ld),
    .ready      (ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h expected=%h (ready,valid,done,sout)", tag, got, exp);
    end
  endtask

  function automatic obs_t observed();
    obs_t o;
    o.ready = ready;
    o.valid = sout_valid;
    o.done  = done;
    o.sout  = sout;
    return o;
  endfunction

  // Expand one accepted word into the list of cycles it should occupy on the line.
  task automatic push_word(input logic [W-1:0] word);
    obs_t e;
    int   nbits;
    nbits = W;
`ifdef REG_DESLOC_PARITY_EN
    nbits = W + 1;
`endif
    for (int k = 0; k < nbits; k++) begin
      e.ready = 1'b0;
      e.valid = 1'b1;
      e.done  = (k == nbits - 1);
      e.sout  = (k < W) ? word[W-1-k] : logic'($countones(word) % 2);
      exp_q.push_back(e);
    end
  endtask

  // Called at mid-cycle: drive inputs, advance one active (falling) edge, check.
  task automatic cycle(input string tag, input logic ld_v, input logic [W-1:0] d_v);
    ld = ld_v;
    d  = d_v;
    @(negedge clk);
    if (cur_exp.ready == 1'b0) begin
      cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : idle_obs;
    end else if (ld_v) begin
      push_word(d_v);
      cur_exp = exp_q.pop_front();
    end else begin
      cur_exp = idle_obs;
    end
    @(posedge clk);
    check_val($sformatf("%s ld=%0b d=%b", tag, ld_v, d_v), 32'(observed()), 32'(cur_exp));
    $display("cyc %s ld=%0b d=%b -> ready=%0b valid=%0b done=%0b sout=%0b",
             tag, ld_v, d_v, ready, sout_valid, done, sout);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    idle_obs   = '{ready: 1'b1, valid: 1'b0, done: 1'b0, sout: 1'b0};
    cur_exp    = idle_obs;
    rst_n = 1'b0;
    ld    = 1'b0;
    d     = '0;
    @(posedge clk);
    @(posedge clk);
    check_val("reset_state", 32'(observed()), 32'(idle_obs));
    rst_n = 1'b1;

    // Basic shift of 1011
    cycle("basic", 1'b1, 4'b1011);
    for (int i = 0; i < 6; i++) cycle("basic", 1'b0, 4'b0000);

    // Loads while busy are ignored; the second word goes only after ready returns
    cycle("busy", 1'b1, 4'b1011);
    for (int i = 0; i < 3; i++) cycle("busy", 1'b1, 4'b0110);
    for (int i = 0; i < 8; i++) cycle("busy", 1'b1, 4'b0110);
    for (int i = 0; i < 3; i++) cycle("busy", 1'b0, 4'b0000);

    // Continuous ld: one idle cycle between repeated words
    for (int i = 0; i < 14; i++) cycle("cont", 1'b1, 4'b1100);
    for (int i = 0; i < 6; i++) cycle("cont", 1'b0, 4'b0000);

    // Asynchronous reset in the middle of a word, between clock edges
    cycle("rst", 1'b1, 4'b1011);
    cycle("rst", 1'b0, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_immediate", 32'(observed()), 32'(idle_obs));
    exp_q.delete();
    cur_exp = idle_obs;
    @(negedge clk);
    @(posedge clk);
    check_val("reset_held", 32'(observed()), 32'(idle_obs));
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 4'b0001);
    for (int i = 0; i < 6; i++) cycle("post_rst", 1'b0, 4'b0000);

    // Boundary patterns
    cycle("zeros", 1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) cycle("zeros", 1'b0, 4'b0000);
    cycle("ones", 1'b1, 4'b1111);
    for (int i = 0; i < 6; i++) cycle("ones", 1'b0, 4'b0000);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle("rand", logic'($urandom_range(0, 1)), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
